// File: rtl/camera_pix_packer.sv
// Camera capture back-end: frame drop, ROI window, pixel packing and an output FIFO.
// Define CAMERA_PIX_DECIM_EN to build the column/row decimation logic.
module camera_pix_packer #(
    parameter int unsigned PIX_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_vsync_pol_i,
    input  logic                 cfg_framedrop_en_i,
    input  logic [5:0]           cfg_framedrop_val_i,
    input  logic                 cfg_slice_en_i,
    input  logic [15:0]          cfg_llx_i,
    input  logic [15:0]          cfg_lly_i,
    input  logic [15:0]          cfg_urx_i,
    input  logic [15:0]          cfg_ury_i,
    input  logic [3:0]           cfg_decim_x_i,
    input  logic [3:0]           cfg_decim_y_i,
    input  logic [PIX_WIDTH-1:0] pix_data_i,
    input  logic                 pix_valid_i,
    input  logic                 pix_hsync_i,
    input  logic                 pix_vsync_i,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic                 sof_o,
    output logic                 ovf_o,
    output logic [15:0]          ovf_cnt_o
);

    localparam int unsigned PACK = OUT_WIDTH / PIX_WIDTH;
    localparam int unsigned KW   = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StWaitSof, StActive, StDrop, StFlush} state_e;

    state_e state_q, state_d;

    logic vs, vs_q, hs_q, en_q, sof_q;
    logic sof, eof, hs_fall, pix_strobe;

    assign vs         = pix_vsync_i ^ cfg_vsync_pol_i;
    assign sof        = vs & ~vs_q;
    assign eof        = ~vs & vs_q;
    assign hs_fall    = hs_q & ~pix_hsync_i;
    assign pix_strobe = pix_valid_i & pix_hsync_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vs_q  <= 1'b0;
            hs_q  <= 1'b0;
            en_q  <= 1'b0;
            sof_q <= 1'b0;
        end else begin
            vs_q  <= vs;
            hs_q  <= pix_hsync_i;
            en_q  <= cfg_en_i;
            sof_q <= sof & cfg_en_i;
        end
    end

    assign sof_o = sof_q;

    // Frame state machine
    logic [5:0] fcnt_q;

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StWaitSof;
                StWaitSof: if (sof) state_d = (fcnt_q == 6'd0) ? StActive : StDrop;
                StActive:  if (eof) state_d = StFlush;
                StDrop:    if (eof) state_d = StWaitSof;
                StFlush:   state_d = StWaitSof;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            fcnt_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            if (!cfg_en_i) begin
                fcnt_q <= 6'd0;
            end else if (state_q == StWaitSof && sof) begin
                if (cfg_framedrop_en_i && fcnt_q < cfg_framedrop_val_i) fcnt_q <= fcnt_q + 6'd1;
                else                                                      fcnt_q <= 6'd0;
            end
        end
    end

    // Per-frame configuration and pixel position
    logic        slice_en_q;
    logic [15:0] llx_q, lly_q, urx_q, ury_q, row_q, col_q;
    logic        in_win, phase_ok, keep;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slice_en_q <= 1'b0;
            llx_q      <= 16'd0;
            lly_q      <= 16'd0;
            urx_q      <= 16'd0;
            ury_q      <= 16'd0;
            row_q      <= 16'd0;
            col_q      <= 16'd0;
        end else begin
            if (sof) begin
                slice_en_q <= cfg_slice_en_i;
                llx_q      <= cfg_llx_i;
                lly_q      <= cfg_lly_i;
                urx_q      <= cfg_urx_i;
                ury_q      <= cfg_ury_i;
            end
            if (!cfg_en_i || sof) begin
                row_q <= 16'd0;
                col_q <= 16'd0;
            end else if (hs_fall) begin
                col_q <= 16'd0;
                if (row_q != 16'hFFFF) row_q <= row_q + 16'd1;
            end else if (pix_strobe && col_q != 16'hFFFF) begin
                col_q <= col_q + 16'd1;
            end
        end
    end

    assign in_win = ~slice_en_q |
                    ((col_q >= llx_q) & (col_q <= urx_q) & (row_q >= lly_q) & (row_q <= ury_q));

`ifdef CAMERA_PIX_DECIM_EN
    logic [3:0] decx_q, decy_q, xph_q, yph_q;
    logic       row_in;

    assign row_in = ~slice_en_q | ((row_q >= lly_q) & (row_q <= ury_q));

    // Phases only advance on pixels/lines inside the window so decimation aligns to its corner.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            decx_q <= 4'd0;
            decy_q <= 4'd0;
            xph_q  <= 4'd0;
            yph_q  <= 4'd0;
        end else begin
            if (sof) begin
                decx_q <= cfg_decim_x_i;
                decy_q <= cfg_decim_y_i;
            end
            if (!cfg_en_i || sof) begin
                xph_q <= 4'd0;
                yph_q <= 4'd0;
            end else if (hs_fall) begin
                xph_q <= 4'd0;
                if (row_in) yph_q <= (yph_q == decy_q) ? 4'd0 : yph_q + 4'd1;
            end else if (pix_strobe && in_win) begin
                xph_q <= (xph_q == decx_q) ? 4'd0 : xph_q + 4'd1;
            end
        end
    end

    assign phase_ok = (xph_q == 4'd0) & (yph_q == 4'd0);
`else
    logic unused_decim;
    assign unused_decim = ^{cfg_decim_x_i, cfg_decim_y_i};
    assign phase_ok     = 1'b1;
`endif

    // A SOF inside ACTIVE restarts the frame, so that cycle's pixel is not kept.
    assign keep = (state_q == StActive) & pix_strobe & in_win & phase_ok & ~sof;

    // Packer
    logic [OUT_WIDTH-1:0] pack_buf_q, word_full, word_q;
    logic [KW-1:0]        k_q;
    logic                 word_vld_q, word_last_q;

    always_comb begin
        word_full = pack_buf_q;
        word_full[32'(k_q) * PIX_WIDTH +: PIX_WIDTH] = pix_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pack_buf_q  <= '0;
            k_q         <= '0;
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            word_last_q <= 1'b0;
        end else if (!cfg_en_i) begin
            pack_buf_q  <= '0;
            k_q         <= '0;
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            word_last_q <= 1'b0;
        end else begin
            word_vld_q <= 1'b0;
            if (state_q == StActive && sof) begin
                pack_buf_q <= '0;
                k_q        <= '0;
            end else if (keep) begin
                if (k_q == KW'(PACK - 1)) begin
                    word_q      <= word_full;
                    word_last_q <= 1'b0;
                    word_vld_q  <= 1'b1;
                    pack_buf_q  <= '0;
                    k_q         <= '0;
                end else begin
                    pack_buf_q <= word_full;
                    k_q        <= k_q + KW'(1);
                end
            end else if (state_q == StFlush && k_q != '0) begin
                word_q      <= pack_buf_q;
                word_last_q <= 1'b1;
                word_vld_q  <= 1'b1;
                pack_buf_q  <= '0;
                k_q         <= '0;
            end
        end
    end

    // Output FIFO
    logic [OUT_WIDTH-1:0]  mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q, last_ptr;
    logic [AW:0]           count_q;
    logic                  full, pop, push_ok, push_drop, push_last, mark_now;

    assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop       = out_valid_o & out_ready_i;
    assign push_ok   = word_vld_q & (~full | pop);
    assign push_drop = word_vld_q & full & ~pop;
    // A full word completing right at EOF is pushed during FLUSH and becomes the frame's last.
    assign push_last = word_last_q | (state_q == StFlush);
    assign last_ptr  = wr_ptr_q - AW'(1);
    // Nothing left to flush: tag the newest word still queued instead.
    assign mark_now  = (state_q == StFlush) & (k_q == '0) & ~word_vld_q;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_data[wr_ptr_q] <= word_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_last_q <= '0;
        end else if (!cfg_en_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_last_q <= '0;
        end else begin
            if (push_ok) begin
                mem_last_q[wr_ptr_q] <= push_last;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + (AW + 1)'(1);
            else if (!push_ok && pop) count_q <= count_q - (AW + 1)'(1);
            if (mark_now && count_q != '0) mem_last_q[last_ptr] <= 1'b1;
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_data[rd_ptr_q] : '0;
    assign out_last_o  = out_valid_o & (mem_last_q[rd_ptr_q] | (mark_now & (rd_ptr_q == last_ptr)));

    // Overflow accounting
    logic        ovf_q;
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 16'd0;
        end else if (cfg_en_i && !en_q) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 16'd0;
        end else if (cfg_en_i && push_drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_o     = ovf_q;
    assign ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_camera_pix_packer.sv
// Directed self-checking bench for camera_pix_packer (PIX_WIDTH=16, OUT_WIDTH=32, FIFO_DEPTH=8).
`timescale 1ns/1ps
module tb_camera_pix_packer;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cfg_en_i, cfg_vsync_pol_i, cfg_framedrop_en_i, cfg_slice_en_i;
    logic [5:0]  cfg_framedrop_val_i;
    logic [15:0] cfg_llx_i, cfg_lly_i, cfg_urx_i, cfg_ury_i;
    logic [3:0]  cfg_decim_x_i, cfg_decim_y_i;
    logic [15:0] pix_data_i;
    logic        pix_valid_i, pix_hsync_i, pix_vsync_i;
    logic [31:0] out_data_o;
    logic        out_valid_o, out_ready_i, out_last_o, sof_o, ovf_o;
    logic [15:0] ovf_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [32:0] got_q[$];
    int          sof_cnt = 0;
    int          valid_cyc = 0;

    camera_pix_packer #(
        .PIX_WIDTH (16),
        .OUT_WIDTH (32),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cfg_en_i           (cfg_en_i),
        .cfg_vsync_pol_i    (cfg_vsync_pol_i),
        .cfg_framedrop_en_i (cfg_framedrop_en_i),
        .cfg_framedrop_val_i(cfg_framedrop_val_i),
        .cfg_slice_en_i     (cfg_slice_en_i),
        .cfg_llx_i          (cfg_llx_i),
        .cfg_lly_i          (cfg_lly_i),
        .cfg_urx_i          (cfg_urx_i),
        .cfg_ury_i          (cfg_ury_i),
        .cfg_decim_x_i      (cfg_decim_x_i),
        .cfg_decim_y_i      (cfg_decim_y_i),
        .pix_data_i         (pix_data_i),
        .pix_valid_i        (pix_valid_i),
        .pix_hsync_i        (pix_hsync_i),
        .pix_vsync_i        (pix_vsync_i),
        .out_data_o         (out_data_o),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_last_o         (out_last_o),
        .sof_o              (sof_o),
        .ovf_o              (ovf_o),
        .ovf_cnt_o          (ovf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every accepted word {last, data} and sof pulses, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (out_valid_o && out_ready_i) got_q.push_back({out_last_o, out_data_o});
            if (sof_o) sof_cnt++;
            if (out_valid_o) valid_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Idle, SOF cycle, lines of ppl pixels with a one-cycle hsync gap; EOF with the last gap.
    task automatic send_frame(input int lines, input int ppl, input int base);
        pix_vsync_i = 1'b0; pix_hsync_i = 1'b0; pix_valid_i = 1'b0;
        tick();
        pix_vsync_i = 1'b1;
        tick();
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < ppl; c++) begin
                pix_hsync_i = 1'b1; pix_valid_i = 1'b1;
                pix_data_i  = 16'(base + l * ppl + c + 1);
                tick();
            end
            pix_hsync_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = 16'd0;
            if (l == lines - 1) pix_vsync_i = 1'b0;
            tick();
        end
        repeat (2) tick();
    endtask

    function automatic logic [32:0] word_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return '1;
    endfunction

    task automatic test_reset();
        rstn_i = 1'b0;
        cfg_en_i = 1'b0; cfg_vsync_pol_i = 1'b0; cfg_framedrop_en_i = 1'b0;
        cfg_framedrop_val_i = 6'd0; cfg_slice_en_i = 1'b0;
        cfg_llx_i = 16'd0; cfg_lly_i = 16'd0; cfg_urx_i = 16'd0; cfg_ury_i = 16'd0;
        cfg_decim_x_i = 4'd0; cfg_decim_y_i = 4'd0;
        pix_data_i = 16'd0; pix_valid_i = 1'b0; pix_hsync_i = 1'b0; pix_vsync_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        checks++; if (ovf_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_ovf_cnt: got %h want 0", ovf_cnt_o); end
        rstn_i = 1'b1;
        tick();
        begin
            int v0 = valid_cyc;
            int s0 = sof_cnt;
            for (int i = 0; i < 24; i++) begin
                pix_vsync_i = (i % 8) >= 4; pix_hsync_i = (i % 3) != 0;
                pix_valid_i = 1'b1; pix_data_i = 16'(i + 1);
                tick();
            end
            pix_vsync_i = 1'b0; pix_hsync_i = 1'b0; pix_valid_i = 1'b0;
            repeat (3) tick();
            checks++; if (valid_cyc !== v0) begin errors++; $display("FAIL dis_valid_cycles: got %0d want %0d", valid_cyc, v0); end
            checks++; if (sof_cnt !== s0) begin errors++; $display("FAIL dis_sof: got %0d want %0d", sof_cnt, s0); end
        end
        checks++; if ({out_data_o, out_last_o, sof_o, ovf_o} !== 35'd0) begin
            errors++; $display("FAIL dis_outputs: got %h/%b/%b/%b want 0", out_data_o, out_last_o, sof_o, ovf_o);
        end
    endtask

    task automatic test_basic();
        int s = got_q.size();
        send_frame(2, 4, 0);
        repeat (4) tick();
        checks++; if (got_q.size() - s !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_q.size() - s); end
        for (int i = 0; i < 4; i++) begin
            logic [32:0] exp;
            exp = {(i == 3), 16'(2 * i + 2), 16'(2 * i + 1)};
            checks++; if (word_at(s + i) !== exp) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, word_at(s + i), exp); end
        end
    endtask

    task automatic test_partial();
        int s = got_q.size();
        send_frame(1, 3, 0);
        repeat (4) tick();
        checks++; if (got_q.size() - s !== 2) begin errors++; $display("FAIL partial_count: got %0d want 2", got_q.size() - s); end
        checks++; if (word_at(s) !== {1'b0, 32'h0002_0001}) begin errors++; $display("FAIL partial_word0: got %h want 000020001", word_at(s)); end
        checks++; if (word_at(s + 1) !== {1'b1, 32'h0000_0003}) begin errors++; $display("FAIL partial_word1: got %h want 100000003", word_at(s + 1)); end
    endtask

    task automatic test_roi();
        int s = got_q.size();
        cfg_slice_en_i = 1'b1; cfg_llx_i = 16'd1; cfg_urx_i = 16'd2; cfg_lly_i = 16'd1; cfg_ury_i = 16'd1;
        out_ready_i = 1'b0;
        send_frame(4, 4, 0);
        checks++; if (out_data_o !== 32'h0007_0006) begin errors++; $display("FAIL roi_data: got %h want 00070006", out_data_o); end
        checks++; if (out_last_o !== 1'b1) begin errors++; $display("FAIL roi_last: got %b want 1", out_last_o); end
        out_ready_i = 1'b1;
        repeat (4) tick();
        checks++; if (got_q.size() - s !== 1) begin errors++; $display("FAIL roi_count: got %0d want 1", got_q.size() - s); end
        cfg_slice_en_i = 1'b0;
    endtask

    task automatic test_framedrop();
        int s = got_q.size();
        int s0 = sof_cnt;
        cfg_framedrop_en_i = 1'b1; cfg_framedrop_val_i = 6'd2;
        for (int f = 0; f < 6; f++) send_frame(1, 2, f * 16);
        repeat (4) tick();
        checks++; if (sof_cnt - s0 !== 6) begin errors++; $display("FAIL fd_sof: got %0d want 6", sof_cnt - s0); end
        checks++; if (got_q.size() - s !== 2) begin errors++; $display("FAIL fd_count: got %0d want 2", got_q.size() - s); end
        checks++; if (word_at(s) !== {1'b1, 32'h0002_0001}) begin errors++; $display("FAIL fd_frame0: got %h want 100020001", word_at(s)); end
        checks++; if (word_at(s + 1) !== {1'b1, 32'h0032_0031}) begin errors++; $display("FAIL fd_frame3: got %h want 100320031", word_at(s + 1)); end
        cfg_framedrop_en_i = 1'b0; cfg_framedrop_val_i = 6'd0;
    endtask

    task automatic test_overflow();
        int s = got_q.size();
        out_ready_i = 1'b0;
        send_frame(1, 40, 0);
        checks++; if (out_data_o !== 32'h0002_0001) begin errors++; $display("FAIL ovf_head_stable: got %h want 00020001", out_data_o); end
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_o); end
        checks++; if (ovf_cnt_o !== 16'd12) begin errors++; $display("FAIL ovf_cnt: got %0d want 12", ovf_cnt_o); end
        out_ready_i = 1'b1;
        repeat (12) tick();
        checks++; if (got_q.size() - s !== 8) begin errors++; $display("FAIL ovf_drain_count: got %0d want 8", got_q.size() - s); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            logic [32:0] got;
            exp = {16'(2 * i + 2), 16'(2 * i + 1)};
            got = word_at(s + i);
            checks++; if (got[31:0] !== exp) begin errors++; $display("FAIL ovf_drain%0d: got %h want %h", i, got[31:0], exp); end
        end
        cfg_en_i = 1'b0;
        tick();
        checks++; if (ovf_cnt_o !== 16'd12) begin errors++; $display("FAIL ovf_held: got %0d want 12", ovf_cnt_o); end
        cfg_en_i = 1'b1;
        tick();
        checks++; if ({ovf_o, ovf_cnt_o} !== 17'd0) begin errors++; $display("FAIL ovf_clear: got %b/%0d want 0/0", ovf_o, ovf_cnt_o); end
    endtask

`ifdef CAMERA_PIX_DECIM_EN
    task automatic test_decim();
        int s = got_q.size();
        cfg_decim_x_i = 4'd1; cfg_decim_y_i = 4'd0;
        out_ready_i = 1'b0;
        send_frame(1, 8, 0);
        out_ready_i = 1'b1;
        repeat (4) tick();
        checks++; if (got_q.size() - s !== 2) begin errors++; $display("FAIL decim_count: got %0d want 2", got_q.size() - s); end
        checks++; if (word_at(s) !== {1'b0, 32'h0003_0001}) begin errors++; $display("FAIL decim_word0: got %h want 000030001", word_at(s)); end
        checks++; if (word_at(s + 1) !== {1'b1, 32'h0007_0005}) begin errors++; $display("FAIL decim_word1: got %h want 100070005", word_at(s + 1)); end
        cfg_decim_x_i = 4'd0;
    endtask
`endif

    initial begin
        test_reset();
        cfg_en_i = 1'b1;
        tick();
        test_basic();
        test_partial();
        test_roi();
        test_framedrop();
        test_overflow();
`ifdef CAMERA_PIX_DECIM_EN
        test_decim();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
